// File: rtl/fir_pkg.sv
// fir_pkg: widths and default configuration shared by the FIR and its decimating quantiser.
package fir_pkg;
    localparam int FIR_SUM_W         = 18;
    localparam int FIR_SAMPLE_W      = 8;
    localparam int FIR_COEF_SUM_LOG2 = 8;
    localparam int FIR_DQ_DECIM      = 4;
    localparam int FIR_DQ_DEPTH      = 4;
endpackage

// File: rtl/fir_dq_fifo.sv
// fir_dq_fifo: synchronous FIFO with a registered head, occupancy output and push/pop while full.
// Ports: clk, reset (async, active-high), push/wdata (write side, dropped when full without pop),
//        ready (consumer accept), dout/valid (registered head), level (occupancy), drop (push lost).
module fir_dq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [WIDTH-1:0]        wdata,
    input  logic                    ready,
    output logic [WIDTH-1:0]        dout,
    output logic                    valid,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    drop
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] rest;
    logic pop, full, wr;
    assign pop  = valid && ready;
    assign full = level == (AW+1)'(DEPTH);
    assign wr   = push && (!full || pop);
    assign drop = push && full && !pop;
    // entries already in memory that survive this cycle's pop; a new write is only
    // exposed on dout one cycle after it lands, which keeps dout a pure memory read
    assign rest = level - (AW+1)'(pop);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            valid  <= 1'b0;
            dout   <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            level <= rest + (AW+1)'(wr);
            valid <= rest != '0;
            if (rest != '0) dout <= mem[rd_ptr + AW'(pop)];
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/fir_decim_quant.sv
// fir_decim_quant: decimates the FIR sum, rounds/shifts/saturates it, and queues results in a FIFO.
// Ports: clk, reset (async, active-high), din/din_valid (FIR sum), dout/dout_valid/dout_ready
//        (output handshake), ovf/ovf_clr (sticky drop flag), level (FIFO occupancy).
// Option FIR_DQ_SATCNT_EN adds sat_cnt[15:0], a saturating count of clamped kept samples.
module fir_decim_quant
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_SUM_W,
    parameter int OUT_W = FIR_SAMPLE_W,
    parameter int SHIFT = FIR_COEF_SUM_LOG2,
    parameter int DECIM = FIR_DQ_DECIM,
    parameter int DEPTH = FIR_DQ_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IN_W-1:0]         din,
    input  logic                    din_valid,
    output logic [OUT_W-1:0]        dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    ovf,
    input  logic                    ovf_clr,
    output logic [$clog2(DEPTH):0]  level
`ifdef FIR_DQ_SATCNT_EN
    ,
    output logic [15:0]             sat_cnt
`endif
);
    localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;
    localparam logic [IN_W:0] HALF = (IN_W+1)'(1) << (SHIFT - 1);
    localparam logic [IN_W:0] QMAX = (IN_W+1)'((1 << OUT_W) - 1);
    logic [PW-1:0] phase;
    logic [IN_W:0] r;
    logic [OUT_W-1:0] q, stage;
    logic keep, sat, stage_valid, drop;
    assign keep = din_valid && phase == '0;
    // one extra bit so the rounding offset cannot overflow before the shift
    assign r    = ({1'b0, din} + HALF) >> SHIFT;
    assign sat  = r > QMAX;
    assign q    = sat ? '1 : r[OUT_W-1:0];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase       <= '0;
            stage_valid <= 1'b0;
            stage       <= '0;
            ovf         <= 1'b0;
        end else begin
            if (din_valid) phase <= phase == PW'(DECIM - 1) ? '0 : phase + PW'(1);
            stage_valid <= keep;
            if (keep) stage <= q;
            ovf <= drop || (ovf && !ovf_clr);
        end
    end
`ifdef FIR_DQ_SATCNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sat_cnt <= '0;
        else if (ovf_clr) sat_cnt <= '0;
        else if (keep && sat && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
    end
`endif
    fir_dq_fifo #(.DEPTH(DEPTH), .WIDTH(OUT_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (stage_valid),
        .wdata (stage),
        .ready (dout_ready),
        .dout  (dout),
        .valid (dout_valid),
        .level (level),
        .drop  (drop)
    );
endmodule

// File: tb/tb_fir_decim_quant.sv
// tb_fir_decim_quant: three instances (DECIM 4, 1, 3) checked against a queue-based model every cycle.
module tb_fir_decim_quant;
    localparam int N = 3;
    localparam int DEPTH = 4;
    localparam int DEC [N] = '{4, 1, 3};

    logic clk = 1'b0;
    logic reset;
    logic [17:0] din [N];
    logic dv [N], rdy [N], oclr [N];
    logic [7:0] dout [N];
    logic dvld [N], ovf [N];
    logic [2:0] lvl [N];
`ifdef FIR_DQ_SATCNT_EN
    logic [15:0] sat [N];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        fir_decim_quant #(.IN_W(18), .OUT_W(8), .SHIFT(8),
                          .DECIM(g == 0 ? 4 : (g == 1 ? 1 : 3)), .DEPTH(DEPTH)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .din        (din[g]),
            .din_valid  (dv[g]),
            .dout       (dout[g]),
            .dout_valid (dvld[g]),
            .dout_ready (rdy[g]),
            .ovf        (ovf[g]),
            .ovf_clr    (oclr[g]),
            .level      (lvl[g])
`ifdef FIR_DQ_SATCNT_EN
            ,
            .sat_cnt    (sat[g])
`endif
        );
    end

    task automatic chk(input bit ok, input string name, input int inst, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s[%0d] got %0d expected %0d at %0t", name, inst, act, exp, $time);
        end
    endtask

    // model: outputs follow directly from the rules (round-half-up divide, clamp, keep every DECIM-th)
    function automatic int quant(input int x);
        int r;
        r = (x + 128) / 256;
        return r > 255 ? 255 : r;
    endfunction

    int mq [N][$];
    int me [N][$];
    int mlog [N][$];
    int mphase [N], mstg [N], mlast [N], msat [N];
    bit mstg_v [N], movf [N];
    int ecnt;
    bit m_pop, m_full, m_drop;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ecnt = 0;
            for (int i = 0; i < N; i++) begin
                mq[i].delete();
                me[i].delete();
                mphase[i] = 0;
                mstg_v[i] = 0;
                mstg[i] = 0;
                movf[i] = 0;
                mlast[i] = 0;
                msat[i] = 0;
            end
        end else begin
            ecnt++;
            for (int i = 0; i < N; i++) begin
                m_pop = dvld[i] && rdy[i];
                m_full = mq[i].size() == DEPTH;
                m_drop = 0;
                if (m_pop && mq[i].size() > 0) begin
                    mlast[i] = mq[i].pop_front();
                    void'(me[i].pop_front());
                    mlog[i].push_back(mlast[i]);
                end
                if (mstg_v[i]) begin
                    if (m_full && !m_pop) m_drop = 1;
                    else begin
                        mq[i].push_back(mstg[i]);
                        me[i].push_back(ecnt);
                    end
                end
                if (m_drop) movf[i] = 1;
                else if (oclr[i]) movf[i] = 0;
                mstg_v[i] = dv[i] && mphase[i] == 0;
                if (oclr[i]) msat[i] = 0;
                else if (mstg_v[i] && (int'(din[i]) + 128) / 256 > 255 && msat[i] < 65535) msat[i]++;
                if (mstg_v[i]) mstg[i] = quant(int'(din[i]));
                if (dv[i]) mphase[i] = (mphase[i] + 1) % DEC[i];
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                chk(int'(lvl[i]) == mq[i].size(), "level", i, lvl[i], mq[i].size());
                chk(ovf[i] == movf[i], "ovf", i, ovf[i], movf[i]);
                if (dvld[i])
                    chk(mq[i].size() > 0 && int'(dout[i]) == mq[i][0], "head", i, dout[i],
                        mq[i].size() > 0 ? mq[i][0] : -1);
                else
                    chk(int'(dout[i]) == mlast[i], "hold", i, dout[i], mlast[i]);
                if (mq[i].size() > 0 && me[i][0] < ecnt)
                    chk(dvld[i] == 1'b1, "latency", i, dvld[i], 1);
`ifdef FIR_DQ_SATCNT_EN
                chk(int'(sat[i]) == msat[i], "sat_cnt", i, sat[i], msat[i]);
`endif
            end
        end
    end

    task automatic check_log(input int i, input int n, input int e0, e1, e2, e3, e4);
        int e [5];
        e = '{e0, e1, e2, e3, e4};
        chk(mlog[i].size() == n, "log_len", i, mlog[i].size(), n);
        for (int j = 0; j < n && j < mlog[i].size(); j++)
            chk(mlog[i][j] == e[j], "log_val", i, mlog[i][j], e[j]);
        mlog[i].delete();
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int rnd [5];
        rnd = '{383, 384, 65280, 65407, 65408};
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            din[i] = '0;
            dv[i] = 1'b0;
            rdy[i] = 1'b0;
            oclr[i] = 1'b0;
        end
        step(3);
        for (int i = 0; i < N; i++) begin
            chk(dout[i] == 8'd0, "rst_dout", i, dout[i], 0);
            chk(dvld[i] == 1'b0, "rst_valid", i, dvld[i], 0);
            chk(ovf[i] == 1'b0, "rst_ovf", i, ovf[i], 0);
            chk(lvl[i] == 3'd0, "rst_level", i, lvl[i], 0);
        end
        #2 reset = 1'b0;
        step(1);

        // DECIM=4 ramp: every 4th sample, visible two edges after being kept
        rdy[0] = 1'b1;
        first = -1;
        for (int k = 0; k < 16; k++) begin
            din[0] = 18'(k * 256);
            dv[0] = 1'b1;
            step(1);
            if (dvld[0] && first < 0) first = k;
        end
        dv[0] = 1'b0;
        step(6);
        chk(first == 2, "first_valid", 0, first, 2);
        check_log(0, 4, 0, 4, 8, 12, 0);

        // rounding and clamping, DECIM=1
        rdy[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            din[1] = 18'(rnd[k]);
            dv[1] = 1'b1;
            step(1);
        end
        dv[1] = 1'b0;
        step(6);
        check_log(1, 5, 1, 2, 255, 255, 255);

        // backpressure: 6 samples into a 4-deep FIFO
        rdy[1] = 1'b0;
        for (int j = 0; j < 6; j++) begin
            din[1] = 18'((10 + j) * 256);
            dv[1] = 1'b1;
            step(1);
            chk(int'(lvl[1]) == (j < 4 ? j : 4), "bp_level", 1, lvl[1], j < 4 ? j : 4);
        end
        dv[1] = 1'b0;
        step(1);
        chk(lvl[1] == 3'd4, "full_level", 1, lvl[1], 4);
        chk(ovf[1] == 1'b1, "ovf_set", 1, ovf[1], 1);
        rdy[1] = 1'b1;
        step(8);
        check_log(1, 4, 10, 11, 12, 13, 0);
        chk(ovf[1] == 1'b1, "ovf_sticky", 1, ovf[1], 1);
        oclr[1] = 1'b1;
        step(1);
        oclr[1] = 1'b0;
        chk(ovf[1] == 1'b0, "ovf_clr", 1, ovf[1], 0);

        // full FIFO with push and pop on the same edge
        rdy[1] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            din[1] = 18'((20 + j) * 256);
            dv[1] = 1'b1;
            step(1);
        end
        dv[1] = 1'b0;
        step(2);
        chk(lvl[1] == 3'd4, "pp_full", 1, lvl[1], 4);
        din[1] = 18'(24 * 256);
        dv[1] = 1'b1;
        step(1);
        dv[1] = 1'b0;
        rdy[1] = 1'b1;
        step(1);
        rdy[1] = 1'b0;
        chk(lvl[1] == 3'd4, "pp_level", 1, lvl[1], 4);
        chk(ovf[1] == 1'b0, "pp_ovf", 1, ovf[1], 0);
        rdy[1] = 1'b1;
        step(8);
        check_log(1, 5, 20, 21, 22, 23, 24);

        // gapped valids, DECIM=3
        rdy[2] = 1'b1;
        for (int j = 0; j < 9; j++) begin
            din[2] = 18'((j + 1) * 256);
            dv[2] = 1'b1;
            step(1);
            dv[2] = 1'b0;
            step(2);
        end
        step(4);
        check_log(2, 3, 1, 4, 7, 0, 0);

        // async reset with phase=2 and level=3
        rdy[0] = 1'b0;
        for (int j = 0; j < 10; j++) begin
            din[0] = 18'((30 + j) * 256);
            dv[0] = 1'b1;
            step(1);
        end
        dv[0] = 1'b0;
        step(1);
        chk(lvl[0] == 3'd3, "pre_rst_level", 0, lvl[0], 3);
        #2 reset = 1'b1;
        #1;
        chk(dvld[0] == 1'b0, "arst_valid", 0, dvld[0], 0);
        chk(lvl[0] == 3'd0, "arst_level", 0, lvl[0], 0);
        chk(ovf[0] == 1'b0, "arst_ovf", 0, ovf[0], 0);
        chk(dout[0] == 8'd0, "arst_dout", 0, dout[0], 0);
        step(1);
        #2 reset = 1'b0;
        step(1);
        rdy[0] = 1'b1;
        din[0] = 18'(77 * 256);
        dv[0] = 1'b1;
        step(1);
        dv[0] = 1'b0;
        step(5);
        check_log(0, 1, 77, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
